store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 139 +++++++++++++
 tb/tb_store_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// store_unit: in-order store buffer between the EX/MEM register and data memory.
// Latency: a store accepted on edge N is presented on DM_* in cycle N+1; there is no combinational bypass.
// Backpressure: DM_ready=0 holds the head write stable. full=1 stalls the pipeline, and stores presented while full are ignored.
//
// Ports:
//   clk, rst      - single clock; synchronous active-high reset
//   XM_swFlag     - store request; XM_size (00 byte, 01 half, 10 word, 11 illegal)
//   ALUout        - byte address of the store or of the load
//   XM_MD         - right-justified store data
//   XM_lwFlag     - load in MEM this cycle; ld_hit flags a match against a pending store
//   full          - buffer holds DEPTH entries
//   err_misalign  - a store was rejected as misaligned or illegal on the previous edge
//   DM_we/addr/wdata/be, DM_ready - write port to data memory, driven from the head entry
module store_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          XM_swFlag,
  input  logic [1:0]    XM_size,
  input  logic [31:0]   ALUout,
  input  logic [31:0]   XM_MD,
  input  logic          XM_lwFlag,
  output logic          full,
  output logic          ld_hit,
  output logic          err_misalign,
  output logic          DM_we,
  output logic [AW-1:0] DM_addr,
  output logic [31:0]   DM_wdata,
  output logic [3:0]    DM_be,
  input  logic          DM_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } entry_t;

  entry_t          buf_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            aligned;
  logic            push;
  logic            pop;
  entry_t          new_entry;
  logic [AW-1:0]   req_waddr;
  logic [DEPTH-1:0] hit_vec;

  // Upper address bits lie outside the data memory and are intentionally dropped.
  logic            unused_alu;
  assign unused_alu = ^ALUout[31:AW+2];

  assign req_waddr = ALUout[AW+1:2];

  always_comb begin
    aligned = 1'b0;
    unique case (XM_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ALUout[0];
      2'b10:   aligned = (ALUout[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Lane placement: narrow data is replicated so the enabled lanes always carry it.
  always_comb begin
    new_entry      = '0;
    new_entry.addr = req_waddr;
    unique case (XM_size)
      2'b00: begin
        new_entry.data = {4{XM_MD[7:0]}};
        new_entry.be   = 4'b0001 << ALUout[1:0];
      end
      2'b01: begin
        new_entry.data = {2{XM_MD[15:0]}};
        new_entry.be   = ALUout[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        new_entry.data = XM_MD;
        new_entry.be   = 4'b1111;
      end
    endcase
  end

  assign full  = (count == CW'(DEPTH));
  // Acceptance looks at full as it stands before any pop on the same edge.
  assign push  = XM_swFlag && !full && aligned;
  assign DM_we = (count != '0);
  assign pop   = DM_we && DM_ready;

  assign DM_addr  = buf_q[rd_ptr].addr;
  assign DM_wdata = buf_q[rd_ptr].data;
  assign DM_be    = buf_q[rd_ptr].be;

  // An entry is live if its distance from the read pointer is below count; the head
  // still counts while popping, and the store being pushed this cycle is not yet stored.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    logic [PW-1:0] off;
    assign off        = PW'(g) - rd_ptr;
    assign hit_vec[g] = ({1'b0, off} < count) && (buf_q[g].addr == req_waddr);
  end

  assign ld_hit = XM_lwFlag && (|hit_vec);

  // Payload carries no reset; only count and pointers decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_misalign <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps DEPTH-1 -> 0.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A stalled (full) store will be re-presented, so it is only judged once accepted.
      err_misalign <= XM_swFlag && !full && !aligned;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          XM_swFlag;
  logic [1:0]    XM_size;
  logic [31:0]   ALUout;
  logic [31:0]   XM_MD;
  logic          XM_lwFlag;
  logic          full;
  logic          ld_hit;
  logic          err_misalign;
  logic          DM_we;
  logic [AW-1:0] DM_addr;
  logic [31:0]   DM_wdata;
  logic [3:0]    DM_be;
  logic          DM_ready;

  int n_checks = 0;
  int n_errors = 0;

  store_unit #(.DEPTH(4), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .XM_swFlag    (XM_swFlag),
    .XM_size      (XM_size),
    .ALUout       (ALUout),
    .XM_MD        (XM_MD),
    .XM_lwFlag    (XM_lwFlag),
    .full         (full),
    .ld_hit       (ld_hit),
    .err_misalign (err_misalign),
    .DM_we        (DM_we),
    .DM_addr      (DM_addr),
    .DM_wdata     (DM_wdata),
    .DM_be        (DM_be),
    .DM_ready     (DM_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a store for one edge; returns at the negedge of the cycle after acceptance.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    XM_swFlag = 1'b1;
    XM_size   = sz;
    ALUout    = a;
    XM_MD     = d;
    @(negedge clk);
    XM_swFlag = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    XM_swFlag = 1'b0;
    XM_size   = 2'b00;
    ALUout    = '0;
    XM_MD     = '0;
    XM_lwFlag = 1'b0;
    DM_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_we",   DM_we,        0);
    check("reset_full", full,         0);
    check("reset_hit",  ld_hit,       0);
    check("reset_err",  err_misalign, 0);

    // Word store, memory ready.
    do_store(2'b10, 32'h10, 32'hDEADBEEF);
    check("w_we",    DM_we,    1);
    check("w_addr",  DM_addr,  4);
    check("w_be",    DM_be,    4'b1111);
    check("w_wdata", DM_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("w_we_after", DM_we, 0);

    // Byte then half store, back to back (push and pop on the same edge).
    do_store(2'b00, 32'h13, 32'h000000A5);
    check("b_we",    DM_we,    1);
    check("b_addr",  DM_addr,  4);
    check("b_be",    DM_be,    4'b1000);
    check("b_wdata", DM_wdata, 32'hA5A5A5A5);
    do_store(2'b01, 32'h22, 32'h00001234);
    check("h_we",    DM_we,    1);
    check("h_addr",  DM_addr,  8);
    check("h_be",    DM_be,    4'b1100);
    check("h_wdata", DM_wdata, 32'h12341234);
    @(negedge clk);
    check("h_we_after", DM_we, 0);

    // Fill to DEPTH with memory stalled; fifth store must be ignored.
    DM_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fill_notfull", full, 0);
      do_store(2'b10, 32'h20 + 4 * i, 32'h11111111 * (i + 1));
    end
    check("fill_full", full, 1);
    do_store(2'b10, 32'h30, 32'h55555555);
    check("fill_full5",   full,         1);
    check("fill_err5",    err_misalign, 0);
    check("fill_hold_ad", DM_addr,      8);
    check("fill_hold_da", DM_wdata,     32'h11111111);
    DM_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_we",   DM_we,    1);
      check("drain_addr", DM_addr,  8 + i);
      check("drain_data", DM_wdata, 32'h11111111 * (i + 1));
      @(negedge clk);
    end
    check("drain_we_end",   DM_we, 0);
    check("drain_full_end", full,  0);

    // Misaligned half, then illegal size.
    do_store(2'b01, 32'h01, 32'h0000BEEF);
    check("mis_err1", err_misalign, 1);
    check("mis_we1",  DM_we,        0);
    @(negedge clk);
    check("mis_err1_clr", err_misalign, 0);
    do_store(2'b11, 32'h00, 32'h12345678);
    check("ill_err",  err_misalign, 1);
    check("ill_we",   DM_we,        0);
    @(negedge clk);
    check("ill_err_clr", err_misalign, 0);
    check("ill_we_clr",  DM_we,        0);

    // Load forwarding hazard detection.
    DM_ready = 1'b0;
    do_store(2'b10, 32'h40, 32'hCAFE0000);
    XM_lwFlag = 1'b1;
    ALUout    = 32'h42;
    #1 check("hit_same_word", ld_hit, 1);
    ALUout = 32'h44;
    #1 check("hit_next_word", ld_hit, 0);
    XM_lwFlag = 1'b0;
    ALUout    = 32'h40;
    #1 check("hit_no_load", ld_hit, 0);
    XM_lwFlag = 1'b1;
    DM_ready  = 1'b1;
    #1 check("hit_popping", ld_hit, 1);
    @(negedge clk);
    check("hit_drained_we", DM_we, 0);
    ALUout = 32'h42;
    #1 check("hit_after_drain", ld_hit, 0);
    // A store pushed this cycle is not yet a hazard for a same-cycle load.
    DM_ready  = 1'b0;
    XM_swFlag = 1'b1;
    XM_size   = 2'b10;
    XM_MD     = 32'h50505050;
    ALUout    = 32'h50;
    #1 check("hit_same_cycle_push", ld_hit, 0);
    @(negedge clk);
    XM_swFlag = 1'b0;
    #1 check("hit_after_push", ld_hit, 1);
    XM_lwFlag = 1'b0;

    // Reset mid-drain with three pending entries and a simultaneous push.
    @(negedge clk);
    do_store(2'b10, 32'h54, 32'h54545454);
    do_store(2'b10, 32'h58, 32'h58585858);
    check("pre_rst_we",   DM_we,   1);
    check("pre_rst_addr", DM_addr, 32'h14);
    rst       = 1'b1;
    DM_ready  = 1'b1;
    XM_swFlag = 1'b1;
    XM_size   = 2'b10;
    ALUout    = 32'h70;
    XM_MD     = 32'h70707070;
    @(negedge clk);
    rst       = 1'b0;
    XM_swFlag = 1'b0;
    check("rst_we",   DM_we,        0);
    check("rst_full", full,         0);
    check("rst_err",  err_misalign, 0);
    do_store(2'b10, 32'h60, 32'h600D600D);
    check("post_rst_we",   DM_we,    1);
    check("post_rst_addr", DM_addr,  32'h18);
    check("post_rst_data", DM_wdata, 32'h600D600D);
    @(negedge clk);
    check("post_rst_we_end", DM_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
